// File: rtl/komut_encoder.sv
// Field-to-word encoder for the 32-bit custom ISA with an output FIFO.
// Optional KOMUT_ENC_ERRCNT_EN adds an 8-bit saturating hata_count output.
module komut_encoder #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_type,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [4:0]    in_rd,
  input  logic [3:0]    in_aluop,
  input  logic [31:0]   in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_komut,
  output logic          out_hata,
  output logic [LW-1:0] level
`ifdef KOMUT_ENC_ERRCNT_EN
  ,
  output logic [7:0]    hata_count
`endif
);

  typedef enum logic [1:0] {
    T_R = 2'd0,
    T_I = 2'd1,
    T_U = 2'd2,
    T_B = 2'd3
  } komut_tip_e;

  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [31:0]   komut_d;
  logic          hata_d;
  logic [31:0]   komut_mem [DEPTH];
  logic          hata_mem  [DEPTH];
  logic [LW-2:0] wr_ptr_q, wr_ptr_d;
  logic [LW-2:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  always_comb begin
    komut_d = '0;
    hata_d  = 1'b0;
    unique case (komut_tip_e'(in_type))
      T_R: komut_d = {1'b0, in_aluop[3], 5'b0, in_rs2, in_rs1, in_aluop[2:0], in_rd, 7'b0000001};
      T_I: begin
        komut_d = {in_imm[11:0], in_rs1, in_aluop[2:0], in_rd, 7'b0000011};
        hata_d  = in_aluop[3] | (|in_imm[31:12]);
      end
      T_U: begin
        komut_d = {in_imm[19:0], in_rd, 7'b0000111};
        hata_d  = |in_imm[31:20];
      end
      T_B: begin
        komut_d = {in_imm[12:6], in_rs2, in_rs1, in_aluop[2:0], in_imm[5:1], 7'b0001111};
        hata_d  = in_aluop[3] | in_imm[0] | (|in_imm[31:13]);
      end
      default: ;
    endcase
  end

  // in_ready depends only on reset and occupancy, never on out_ready.
  assign in_ready  = reset && (level_q != FULL);
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = level_q;
  assign out_komut = komut_mem[rd_ptr_q];
  assign out_hata  = hata_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + (LW-1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (LW-1)'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; only pointers and level define what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      komut_mem[wr_ptr_q] <= komut_d;
      hata_mem[wr_ptr_q]  <= hata_d;
    end
  end

`ifdef KOMUT_ENC_ERRCNT_EN
  logic [7:0] hata_cnt_q, hata_cnt_d;

  always_comb begin
    hata_cnt_d = hata_cnt_q;
    if (push && hata_d && (hata_cnt_q != 8'hFF)) hata_cnt_d = hata_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hata_cnt_q <= '0;
    else        hata_cnt_q <= hata_cnt_d;
  end

  assign hata_count = hata_cnt_q;
`endif

endmodule
